audio_pwm_out: RTL and testbench
================================

# audio_pwm_out

Downstream audio output stage that consumes 16-bit signed PCM samples from the sample-memory read path and drives a 1-bit PWM signal to the board's audio amplifier. Samples arrive over a valid/ready handshake into a small FIFO, are drained at a fixed sample rate derived from the system clock, and are converted to an 8-bit-resolution PWM waveform. Priming, underrun detection and muting are handled so that the amplifier never sees garbage after reset or starvation.

## Interface
- CLK_DIV, 2083: system clocks per audio sample (100 MHz / 2083 ≈ 48 kHz); must be ≥ 256.
- FIFO_DEPTH, 8: sample FIFO entries; power of two, ≥ 2.
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- enable  input  1  1 = play, 0 = mute and flush.
- sample_in  input  16  signed two's-complement PCM sample.
- sample_valid  input  1  sample_in valid this cycle.
- sample_ready  output  1  FIFO can accept; transfer when valid && ready.
- underrun_clr  input  1  clears the underrun flag.
- audio_out  output  1  PWM output to amplifier.
- audio_sd  output  1  amplifier enable (1 = on).
- sample_tick  output  1  one-cycle pulse at each sample period.
- underrun  output  1  sticky starvation flag.
- fifo_level  output  log2(FIFO_DEPTH)+1  current FIFO occupancy.

## Operation
- Reset values: sample_ready 0 (it becomes 1 only in PRIME or PLAY), audio_out 0, audio_sd 0, sample_tick 0, underrun 0, fifo_level 0, tick counter 0, PWM counter 0, duty 8'h80, FSM in MUTE.
- Sample tick counter runs 0..CLK_DIV-1 in every state and wraps. sample_tick = 1 in the cycle the count equals CLK_DIV-1.
- FIFO:
  - Push on sample_valid && sample_ready.
  - sample_ready = !full && state != MUTE.
  - No bypass: a push into an empty FIFO is not poppable in the same cycle.
- FSM states:
  - MUTE: audio_sd = 0, FIFO held empty (flushed), current sample = 16'h0000. Goes to PRIME when enable = 1.
  - PRIME: audio_sd = 1, no pops. Goes to PLAY when fifo_level ≥ FIFO_DEPTH/2.
  - PLAY: audio_sd = 1. On each sample_tick:
    - FIFO non-empty: pop the head into the current-sample register.
    - FIFO empty: hold the current sample, set underrun, go to PRIME.
  - From any state, enable = 0 → MUTE on the next clock. This flushes the FIFO and zeroes the current sample.
- Conversion: duty_next = {~cur[15], cur[14:8]}, i.e. top 8 bits converted to offset binary. 16'h0000 maps to 8'h80, 16'h7FFF to 8'hFF, 16'h8000 to 8'h00.
- PWM:
  - 8-bit free-running counter 0..255.
  - duty loads duty_next only when the counter wraps 255→0, so there are no mid-period glitches.
  - audio_out = (pwm_cnt < duty), registered.
  - Duty 0 gives constant low. Duty 255 gives high 255 of 256 clocks.
- underrun: set per PLAY rules. Cleared by underrun_clr. If set and clear coincide, set wins.
- Simultaneous push and pop in PLAY: both occur and fifo_level is unchanged. When the FIFO is full, push is blocked by ready. A pop from full frees one slot; ready rises the next cycle.

## Timing
- Handshake: the sample is written at the rising edge where valid && ready. fifo_level updates in the same edge.
- Pop to current sample: 1 clock after sample_tick.
- Current sample to duty: up to 256 clocks (next PWM wrap).
- duty to audio_out: 1 clock.
- PRIME→PLAY: 1 clock after fifo_level reaches FIFO_DEPTH/2. The first pop happens on the next sample_tick.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous). Release is synchronous to clk.

## Test plan
- Reset, enable = 0, sample_valid = 1 for 1000 clocks → sample_ready = 0, audio_sd = 0, and audio_out is a duty-128 waveform (high 128 of every 256 clocks) after the first PWM wrap.
- Enable = 1, push 4 samples of 16'h7FFF → PLAY entered when fifo_level = 4. After the next sample_tick and PWM wrap, audio_out is high 255/256.
- Push 16'h8000 continuously (one per tick) → audio_out is constantly 0 and underrun stays 0 across 20 ticks.
- Fill 8 samples without ticks in PRIME→PLAY → sample_ready = 0 at fifo_level 8. The first pop raises ready one cycle later.
- Stop pushing in PLAY → underrun = 1 on the tick after the FIFO empties, FSM returns to PRIME, last duty held. underrun_clr pulsed together with a new underrun → flag stays 1.
- Drop enable mid-PLAY with fifo_level 5 → next clock: fifo_level 0, audio_sd 0. Duty becomes 8'h80 at the next PWM wrap.

Source files
------------

// File: rtl/audio_pwm_out.sv
// Audio output stage: PCM samples buffered in a small FIFO, drained at a fixed
// sample rate and rendered as an 8-bit-resolution PWM stream with mute/prime/underrun control.
module audio_pwm_out #(
  parameter int CLK_DIV    = 2083,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic signed [15:0]          sample_in,
  input  logic                        sample_valid,
  output logic                        sample_ready,
  input  logic                        underrun_clr,
  output logic                        audio_out,
  output logic                        audio_sd,
  output logic                        sample_tick,
  output logic                        underrun,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int TW      = $clog2(CLK_DIV);
  localparam int TL      = CLK_DIV - 1;
  localparam int HALF    = FIFO_DEPTH / 2;
  localparam logic [TW-1:0] TICK_LAST = TL[TW-1:0];
  localparam logic [TW-1:0] TICK_ONE  = 1;
  localparam logic [AW:0]   LVL_FULL  = FIFO_DEPTH[AW:0];
  localparam logic [AW:0]   LVL_PRIME = HALF[AW:0];
  localparam logic [AW:0]   LVL_ONE   = 1;
  localparam logic [AW-1:0] PTR_ONE   = 1;

  typedef enum logic [1:0] {MUTE, PRIME, PLAY} state_t;

  state_t             state, state_next;
  logic [TW-1:0]      tick_cnt;
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic signed [15:0] mem [FIFO_DEPTH];
  logic               full, empty, push, pop, flush, underrun_set;
  logic signed [15:0] cur_p0;
  logic [7:0]         pwm_cnt, duty_p1;
  logic               unused_lsb;

  // Top byte of a signed sample re-centred to offset binary (0 -> mid-scale).
  function automatic logic [7:0] to_offset8(input logic signed [7:0] msb);
    return {~msb[7], msb[6:0]};
  endfunction

  assign sample_tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)             tick_cnt <= '0;
    else if (sample_tick) tick_cnt <= '0;
    else                  tick_cnt <= tick_cnt + TICK_ONE;
  end

  assign full         = (fifo_level == LVL_FULL);
  assign empty        = (fifo_level == '0);
  assign sample_ready = !full && (state != MUTE);
  assign push         = sample_valid && sample_ready;
  assign pop          = (state == PLAY) && sample_tick && !empty;
  assign flush        = !enable || (state == MUTE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LVL_ONE;
        2'b01:   fifo_level <= fifo_level - LVL_ONE;
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= sample_in;
  end

  // Stage p0: current sample, popped on the sample tick
  always_ff @(posedge clk) begin
    if (flush)    cur_p0 <= '0;
    else if (pop) cur_p0 <= mem[rd_ptr];
  end

  // Low byte lies below the PWM resolution.
  assign unused_lsb = ^cur_p0[7:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= MUTE;
    else      state <= state_next;
  end

  always_comb begin
    state_next   = state;
    underrun_set = 1'b0;
    case (state)
      MUTE:    state_next = PRIME;
      PRIME:   if (fifo_level >= LVL_PRIME) state_next = PLAY;
      PLAY: begin
        if (sample_tick && empty) begin
          underrun_set = 1'b1;
          state_next   = PRIME;
        end
      end
      default: state_next = MUTE;
    endcase
    if (!enable) state_next = MUTE;
  end

  assign audio_sd = (state != MUTE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)              underrun <= 1'b0;
    else if (underrun_set) underrun <= 1'b1;
    else if (underrun_clr) underrun <= 1'b0;
  end

  // Stage p1: duty reloads only at the PWM wrap; output registered one clock later
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pwm_cnt   <= '0;
      duty_p1   <= 8'h80;
      audio_out <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + 8'd1;
      if (pwm_cnt == 8'hFF) duty_p1 <= to_offset8(cur_p0[15:8]);
      audio_out <= (pwm_cnt < duty_p1);
    end
  end

endmodule

// File: tb/tb_audio_pwm_out.sv
// Directed-sequence bench for audio_pwm_out with randomized samples, checked
// against a queue-based behavioural model and PWM high-count windows.
module tb_audio_pwm_out;
  localparam int CLK_DIV = 300;
  localparam int DEPTH   = 8;
  localparam int MUTE = 0, PRIME = 1, PLAY = 2;

  logic        clk = 1'b0, rst = 1'b0, enable = 1'b0;
  logic        sample_valid = 1'b0, underrun_clr = 1'b0;
  logic [15:0] sample_in = '0;
  logic        sample_ready, audio_out, audio_sd, sample_tick, underrun;
  logic [3:0]  fifo_level;

  audio_pwm_out #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .enable(enable), .sample_in(sample_in),
    .sample_valid(sample_valid), .sample_ready(sample_ready),
    .underrun_clr(underrun_clr), .audio_out(audio_out), .audio_sd(audio_sd),
    .sample_tick(sample_tick), .underrun(underrun), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  int          checks = 0, failures = 0;
  int          m_st, cyc, m_duty, hi_cnt, win_duty;
  logic [15:0] m_q[$];
  logic [15:0] m_cur;
  bit          m_und, last_push, saw_full;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    assert (got === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, expv);
    end
  endtask

  task automatic guard(input string tag, input bit ok);
    checks++;
    assert (ok) else begin
      failures++;
      $error("FAIL %s observed=0 expected=1", tag);
    end
  endtask

  function automatic int to_duty(input logic [15:0] s);
    int v;
    v = int'($signed(s));
    return (v >>> 8) + 128;
  endfunction

  task automatic model_reset();
    m_st = MUTE; m_q.delete(); m_cur = '0; m_und = 0;
    m_duty = 128; cyc = 0; hi_cnt = 0; win_duty = 128;
  endtask

  task automatic reset_checks();
    chk("rst_sample_ready", sample_ready, 0);
    chk("rst_audio_out", audio_out, 0);
    chk("rst_audio_sd", audio_sd, 0);
    chk("rst_sample_tick", sample_tick, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_fifo_level", fifo_level, 0);
  endtask

  // One clock: compare current outputs with the model, then advance both.
  task automatic step();
    bit tick, ready, push, pop, und_set, wrap, en, clr;
    int size_pre, st_pre;
    logic [15:0] cur_pre, din;
    #1;
    tick     = (cyc % CLK_DIV) == CLK_DIV - 1;
    wrap     = (cyc % 256) == 255;
    size_pre = m_q.size();
    st_pre   = m_st;
    ready    = (size_pre < DEPTH) && (m_st != MUTE);
    chk("sample_tick", sample_tick, tick);
    chk("sample_ready", sample_ready, ready);
    chk("fifo_level", fifo_level, size_pre);
    chk("audio_sd", audio_sd, m_st != MUTE);
    chk("underrun", underrun, m_und);
    push    = sample_valid && ready;
    pop     = (m_st == PLAY) && tick && (size_pre > 0);
    und_set = (m_st == PLAY) && tick && (size_pre == 0);
    cur_pre = m_cur; en = enable; clr = underrun_clr; din = sample_in;
    @(posedge clk); #1;
    if (!en) begin
      m_st = MUTE; m_q.delete(); m_cur = '0;
    end else begin
      if (pop)  m_cur = m_q.pop_front();
      if (push) m_q.push_back(din);
      case (st_pre)
        MUTE:    m_st = PRIME;
        PRIME:   if (size_pre >= DEPTH / 2) m_st = PLAY;
        default: if (und_set) m_st = PRIME;
      endcase
    end
    if (und_set) m_und = 1; else if (clr) m_und = 0;
    if (wrap) m_duty = to_duty(cur_pre);
    cyc++;
    last_push = push && en;
    if (m_q.size() == DEPTH) saw_full = 1;
    hi_cnt += int'(audio_out);
    if (wrap) begin
      chk("pwm_high_count", hi_cnt, win_duty);
      hi_cnt = 0;
      win_duty = m_duty;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit done;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    reset_checks();
    rst = 1'b1;

    // Muted: handshake refused, mid-scale PWM
    repeat (1000) begin
      sample_valid = 1'b1; sample_in = 16'($urandom); step();
    end
    sample_valid = 1'b0;

    // Prime with four full-scale positive samples
    enable = 1'b1; n = 0;
    for (int i = 0; i < 20 && n < 4; i++) begin
      sample_valid = 1'b1; sample_in = 16'h7FFF; step();
      if (last_push) n++;
    end
    sample_valid = 1'b0;
    guard("prime_push4", n == 4);
    repeat (CLK_DIV + 600) step();

    // Full-scale negative, one sample per tick, no starvation
    underrun_clr = 1'b1; step(); underrun_clr = 1'b0;
    n = 0;
    for (int i = 0; i < 20 && n < 4; i++) begin
      sample_valid = 1'b1; sample_in = 16'h8000; step();
      if (last_push) n++;
    end
    guard("refill_push4", n == 4);
    repeat (20 * CLK_DIV) begin
      sample_valid = ((cyc % CLK_DIV) == 5); sample_in = 16'h8000; step();
    end
    sample_valid = 1'b0;
    chk("underrun_quiet_20ticks", underrun, 0);

    // Saturate the FIFO across a tick with random samples
    saw_full = 0;
    repeat (CLK_DIV + 10) begin
      sample_valid = 1'b1; sample_in = 16'($urandom); step();
    end
    sample_valid = 1'b0;
    guard("fifo_reached_full", saw_full);

    // Starve until underrun
    for (int i = 0; i < 12 * CLK_DIV && !m_und; i++) step();
    guard("underrun_reached", m_und);
    chk("underrun_flag", underrun, 1);
    chk("sd_after_underrun", audio_sd, 1);
    underrun_clr = 1'b1; step(); underrun_clr = 1'b0;
    chk("underrun_cleared", underrun, 0);

    // Re-prime, drain, and clear exactly on the starving tick
    n = 0;
    for (int i = 0; i < 20 && n < 4; i++) begin
      sample_valid = 1'b1; sample_in = 16'($urandom); step();
      if (last_push) n++;
    end
    sample_valid = 1'b0;
    done = 0;
    for (int i = 0; i < 8 * CLK_DIV && !done; i++) begin
      underrun_clr = (m_st == PLAY) && ((cyc % CLK_DIV) == CLK_DIV - 1) && (m_q.size() == 0);
      done = underrun_clr;
      step();
    end
    underrun_clr = 1'b0;
    guard("coincide_reached", done);
    chk("underrun_set_wins", underrun, 1);

    // Build level 5 in PLAY, then drop enable
    for (int i = 0; i < 4 * CLK_DIV && !(m_st == PLAY && m_q.size() == 5); i++) begin
      sample_valid = (m_q.size() < 5); sample_in = 16'($urandom); step();
    end
    sample_valid = 1'b0;
    guard("level5_in_play", m_st == PLAY && m_q.size() == 5);
    chk("level_before_drop", fifo_level, 5);
    enable = 1'b0; step();
    chk("flush_level", fifo_level, 0);
    chk("flush_sd", audio_sd, 0);
    repeat (600) step();

    // Random traffic, then asynchronous reset mid-operation
    enable = 1'b1;
    repeat (CLK_DIV) begin
      sample_valid = ($urandom_range(0, 3) == 0); sample_in = 16'($urandom); step();
    end
    sample_valid = 1'b0;
    #2 rst = 1'b0;
    #1 reset_checks();
    enable = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    model_reset();
    repeat (300) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
